escalonador_nota: RTL
=====================

Name: escalonador_nota

Overview:
- Round scheduler for the greenhouse scoring datapath.
- Shares one scorer (the nota-assignment unit) across the four sensor channels: temperatura (0), umidade (1), luminosidade (2), pH (3).
- Per round it does four things: waits for the ideal-value memory lookup, scores each channel in turn via `sel`, accumulates the four notas and computes the average, then drives the counter clear (`s_zera`) and the average-register load (`s_reg`).
- Sits between the controller top level, the ideal-value memory, the shared scorer, and the media register and display path.

Parameters:
- MEM_LAT, 1: cycles the memory needs after `tipo_planta` is latched before the ideal values are valid.
- LAT_NOTA, 1: scorer latency in cycles; `sel` is held LAT_NOTA+1 cycles per channel.
- INTERVALO, 8: idle cycles between rounds (≥1).

Ports:
- clock, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- enable, in, 1: run rounds while 1.
- tipo_planta, in, 4: plant type; latched at start of round.
- nota_in, in, 4: scorer output for the currently selected channel.
- sel, out, 2: channel select driven to the sensor/ideal muxes in front of the scorer.
- tipo_lat, out, 4: latched plant type driven to the memory.
- nota_temperatura, out, 4: last captured channel-0 nota.
- nota_umidade, out, 4: last captured channel-1 nota.
- nota_luminosidade, out, 4: last captured channel-2 nota.
- nota_pH, out, 4: last captured channel-3 nota.
- media, out, 4: average of the four notas from the last completed round.
- s_zera, out, 1: clear pulse to the counter/register.
- s_reg, out, 1: load enable to the media register.
- media_valid, out, 1: one-cycle pulse when `media` updates.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE; all outputs, internal counters, `sum` and `canal` go to 0. Reset has priority over everything, including mid-round; it aborts the round with no partial update.
- States are IDLE, ZERA, CONFIG, AMOSTRA, MEDIA, ESPERA. All outputs are registered.
- IDLE:
  - enable=1 → ZERA.
- ZERA (1 cycle):
  - s_zera=1.
  - tipo_lat←tipo_planta; sum←0; canal←0.
  - → CONFIG.
- CONFIG (MEM_LAT cycles):
  - Then → AMOSTRA with lat counter=0.
- AMOSTRA:
  - sel=canal.
  - Channel lasts LAT_NOTA+1 cycles. On its last cycle: the nota register for `canal` ←nota_in; sum←sum+nota_in.
  - If canal=3 → MEDIA; else canal+1, stay in AMOSTRA.
- MEDIA (1 cycle):
  - media←sum[5:2], i.e. floor(sum/4).
  - `sum` is 6 bits; max 60, no overflow.
  - → ESPERA.
- ESPERA (INTERVALO cycles):
  - s_reg=1 and media_valid=1 in the first cycle only.
  - Then → ZERA.
- Round length with defaults: 1 + 1 + 4·2 + 1 + 8 = 19 cycles. ZERA recurs every 19 cycles.
- enable=0 in any non-IDLE state → IDLE next cycle. The round is abandoned; the nota registers and `media` hold their values; s_zera, s_reg and media_valid stay low.
- tipo_planta≠tipo_lat seen in CONFIG, AMOSTRA or ESPERA → ZERA next cycle:
  - The round restarts; no nota or media update from the aborted round.
  - Takes priority over any capture in that same cycle.
- enable=0 and a `tipo_planta` change in the same cycle: enable wins → IDLE.
- `sel` holds its last value in IDLE.
- s_zera and s_reg are never high in the same cycle.

Test Plan:
- Reset then enable=1, tipo_planta=3, nota_in per channel 9,7,5,3:
  - s_zera at cycle 1; sel sequence 0,0,1,1,2,2,3,3.
  - After the round: media=6 and s_reg=media_valid=1 together; next s_zera 19 cycles after the first.
- Notas 9,9,9,8 (sum 35) → media=8 (floor). Notas 15,15,15,15 → media=15, no overflow.
- Change tipo_planta 3→5 during channel 2 of a round → ZERA next cycle with tipo_lat=5; nota_luminosidade, nota_pH and media unchanged; following round completes normally.
- Drop enable during AMOSTRA → IDLE next cycle, busy=0, all notas and media held. Re-raise enable → s_zera on the next cycle.
- Assert reset=0 mid-AMOSTRA (with enable=1) → all outputs 0 after that edge. Release reset → new round starts from ZERA.
- Parameter sweep MEM_LAT=3, LAT_NOTA=2, INTERVALO=4 → each channel holds sel for 3 cycles; round length 1+3+12+1+4=21 cycles.

Source files
------------

// File: rtl/escalonador_nota_if.sv
// Signal bundle between the round scheduler and its neighbours: controller, ideal-value memory,
// shared scorer, media register and display.
interface escalonador_nota_if;
  logic       enable;
  logic [3:0] tipo_planta;
  logic [3:0] nota_in;
  logic [1:0] sel;
  logic [3:0] tipo_lat;
  logic [3:0] nota_temperatura;
  logic [3:0] nota_umidade;
  logic [3:0] nota_luminosidade;
  logic [3:0] nota_pH;
  logic [3:0] media;
  logic       s_zera;
  logic       s_reg;
  logic       media_valid;
  logic       busy;

  modport master (
    output enable, tipo_planta, nota_in,
    input  sel, tipo_lat, nota_temperatura, nota_umidade, nota_luminosidade, nota_pH,
    input  media, s_zera, s_reg, media_valid, busy
  );

  modport slave (
    input  enable, tipo_planta, nota_in,
    output sel, tipo_lat, nota_temperatura, nota_umidade, nota_luminosidade, nota_pH,
    output media, s_zera, s_reg, media_valid, busy
  );
endinterface

// File: rtl/escalonador_nota.sv
// Round scheduler: shares one nota scorer across four sensor channels, then averages the notas.
// Every output is registered from the next-state decision, so it lines up with the state it belongs to.
module escalonador_nota #(
  parameter int MEM_LAT   = 1,
  parameter int LAT_NOTA  = 1,
  parameter int INTERVALO = 8
) (
  input logic               clock,
  input logic               reset,
  escalonador_nota_if.slave bus
);

  localparam int CNT_MAX = (MEM_LAT > INTERVALO) ?
                           ((MEM_LAT > LAT_NOTA + 1) ? MEM_LAT : LAT_NOTA + 1) :
                           ((INTERVALO > LAT_NOTA + 1) ? INTERVALO : LAT_NOTA + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ZERA, CONFIG, AMOSTRA, MEDIA, ESPERA} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       canal_q, canal_d;
  logic [5:0]       sum_q, sum_d;
  logic [3:0][3:0]  nota_q, nota_d;
  logic [3:0]       tipo_lat_q, tipo_lat_d;
  logic [3:0]       media_q, media_d;
  logic [1:0]       sel_q, sel_d;
  logic             s_zera_q, s_zera_d;
  logic             s_reg_q, s_reg_d;
  logic             media_valid_q, media_valid_d;
  logic             busy_q, busy_d;

  logic troca;
  logic ultimo;
  logic captura;
  logic carrega;

  // A plant-type change restarts the round; MEDIA and ZERA are too short to need the check.
  assign troca   = (bus.tipo_planta != tipo_lat_q) &&
                   (state_q == CONFIG || state_q == AMOSTRA || state_q == ESPERA);
  assign ultimo  = (state_q == AMOSTRA) && (cnt_q == CNT_W'(LAT_NOTA));
  assign captura = ultimo && bus.enable && !troca;
  assign carrega = (state_q == MEDIA) && bus.enable;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      canal_q       <= '0;
      sum_q         <= '0;
      nota_q        <= '0;
      tipo_lat_q    <= '0;
      media_q       <= '0;
      sel_q         <= '0;
      s_zera_q      <= 1'b0;
      s_reg_q       <= 1'b0;
      media_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      canal_q       <= canal_d;
      sum_q         <= sum_d;
      nota_q        <= nota_d;
      tipo_lat_q    <= tipo_lat_d;
      media_q       <= media_d;
      sel_q         <= sel_d;
      s_zera_q      <= s_zera_d;
      s_reg_q       <= s_reg_d;
      media_valid_q <= media_valid_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    canal_d = canal_q;
    if (state_q != IDLE && !bus.enable) begin
      state_d = IDLE;
    end else if (troca) begin
      state_d = ZERA;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) state_d = ZERA;
        end
        ZERA: begin
          state_d = CONFIG;
          cnt_d   = '0;
        end
        CONFIG: begin
          if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
            state_d = AMOSTRA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        AMOSTRA: begin
          if (ultimo) begin
            cnt_d = '0;
            if (canal_q == 2'd3) state_d = MEDIA;
            else                 canal_d = canal_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MEDIA: begin
          state_d = ESPERA;
          cnt_d   = '0;
        end
        ESPERA: begin
          if (cnt_q == CNT_W'(INTERVALO - 1)) state_d = ZERA;
          else                                cnt_d   = cnt_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == ZERA) canal_d = '0;
  end

  always_comb begin
    s_zera_d      = (state_d == ZERA);
    s_reg_d       = carrega;
    media_valid_d = carrega;
    busy_d        = (state_d != IDLE);
    tipo_lat_d    = (state_d == ZERA) ? bus.tipo_planta : tipo_lat_q;
    sel_d         = (state_d == AMOSTRA) ? canal_d : sel_q;
    media_d       = carrega ? sum_q[5:2] : media_q;
    nota_d        = nota_q;
    sum_d         = sum_q;
    if (state_d == ZERA) begin
      sum_d = '0;
    end else if (captura) begin
      sum_d           = sum_q + {2'b00, bus.nota_in};
      nota_d[canal_q] = bus.nota_in;
    end
  end

  assign bus.sel               = sel_q;
  assign bus.tipo_lat          = tipo_lat_q;
  assign bus.nota_temperatura  = nota_q[0];
  assign bus.nota_umidade      = nota_q[1];
  assign bus.nota_luminosidade = nota_q[2];
  assign bus.nota_pH           = nota_q[3];
  assign bus.media             = media_q;
  assign bus.s_zera            = s_zera_q;
  assign bus.s_reg             = s_reg_q;
  assign bus.media_valid       = media_valid_q;
  assign bus.busy              = busy_q;

endmodule
